truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer that sits directly upstream of a combinational 3-input logic function and also consumes its output.
- On a start pulse it drives the function's inputs through every combination, 000 to 111 (x is the MSB), one vector per step.
- It samples the function output for each vector and assembles the full truth table as a minterm mask.
- It replaces the hand-written #1 stimulus chains that the team's truth-table benches currently use, so the same sweep can run in clocked designs.

Parameters:
- N, 3, number of function inputs; the mask is 2**N bits wide.
- SETTLE, 0, extra wait cycles after each vector is applied before its sample is taken (0..15).
- EXPECTED, 8'h42, golden mask of width 2**N; used only with TT_CHECK_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- vec  output  N  registered input vector to the function; vec[N-1]=x, vec[0]=z when N=3.
- f_in  input  1  function output, combinationally derived from vec.
- mask  output  2**N  collected truth table; mask[i] = f_in sampled while vec==i.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse after the last sample is taken.
- mismatch  output  1  mask != EXPECTED at completion (TT_CHECK_EN only, else tied 0).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; vec=0, mask=0, busy=0, done=0, mismatch=0; settle counter=0.
- Reset mid-sweep aborts the sweep immediately; no partial done pulse is produced.
- IDLE:
  - busy=0; vec holds 0.
  - start=1 at an edge: go to APPLY, vec=0, mask cleared to 0, settle counter=SETTLE, busy=1 from that edge.
- APPLY:
  - While settle counter>0, decrement it each edge.
  - When the counter is 0, the next edge writes f_in into mask[vec].
  - If vec==2**N-1, go to DONE. Otherwise vec=vec+1 and the counter reloads to SETTLE.
- DONE:
  - done=1 for exactly one cycle; busy=0; mask holds its final value.
  - The next edge returns to IDLE and vec=0.
- Latency: start is sampled at edge E0. Samples are taken at edges E(SETTLE+1)*k+... through E((SETTLE+1)*2**N). done is high for the cycle that follows the final sample. With SETTLE=0 and N=3, samples are at E1..E8 and done is high between E8 and E9.
- mask bits are written one per sample and are visible while the sweep runs. The mask is final only when done=1. It stays stable until the next accepted start.
- start while busy or in DONE is ignored; no restart and no queueing.
- start in the same cycle that DONE returns to IDLE is ignored; start is accepted only in IDLE.
- Wrap-around: vec never exceeds 2**N-1. A vec of width N wraps to 0 only through DONE to IDLE.
- f_in is expected to be settled within one cycle of a vec change when SETTLE=0. SETTLE covers slow or multi-stage consumers.

Optional Feature:
- Macro TT_CHECK_EN.
- Defined:
  - On the edge entering DONE, mismatch is registered as (final mask != EXPECTED).
  - mismatch holds until the next accepted start, which clears it, or until reset.
- Undefined: no comparator is built; mismatch is constant 0 and EXPECTED is unused.

Test Plan:
- Reset then start, with f_in driven by the function f = x'y'z + xyz' on vec -> busy is high for 8 cycles; vec steps 0..7; done pulses once; mask=8'h42.
- Same stimulus with SETTLE=2 -> each vec value is held 3 cycles; done arrives 24 cycles after start; mask=8'h42.
- start pulsed again at vec=3 while busy -> no effect; vec continues to 7; single done pulse; mask=8'h42.
- rst_n driven low asynchronously while vec=5 -> vec, mask, busy and done are 0 at once; no done pulse; the next start gives a full sweep with mask=8'h42.
- TT_CHECK_EN with EXPECTED=8'h42 -> mismatch=0. Force f_in=1 constantly -> mask=8'hFF and mismatch=1 at done. The next start clears mismatch.
- f_in tied 0 and start held high for 20 cycles -> exactly one sweep is accepted, then a new one is accepted on the first IDLE cycle; each sweep gives mask=8'h00 and one done pulse.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a combinational N-input function through every
// input vector, samples its output per vector and builds the minterm mask.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    one-cycle sweep request, accepted only in IDLE
//   vec      registered input vector to the function (vec[N-1] is the MSB)
//   f_in     function output, combinational from vec
//   mask     truth table; mask[i] is f_in sampled while vec == i
//   busy     high while a sweep is in progress
//   done     one-cycle pulse after the last sample
//   mismatch final mask != EXPECTED (only with TT_CHECK_EN, else 0)
//
// Build option: define TT_CHECK_EN to compare the final mask to EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned     N        = 3,
  parameter int unsigned     SETTLE   = 0,
  parameter logic [2**N-1:0] EXPECTED = 8'h42
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N-1:0]    vec,
  input  logic            f_in,
  output logic [2**N-1:0] mask,
  output logic            busy,
  output logic            done,
  output logic            mismatch
);

  localparam logic [N-1:0] VecLast  = N'(2**N - 1);
  localparam logic [3:0]   SettleLd = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [2**N-1:0] mask_q, mask_d;
  logic [3:0]      cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = '0;
          mask_d  = '0;
          cnt_d   = SettleLd;
        end
      end
      S_APPLY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Sample edge: capture f_in for the vector held so far.
          mask_d[vec_q] = f_in;
          if (vec_q == VecLast) begin
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + N'(1);
            cnt_d = SettleLd;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  assign vec  = vec_q;
  assign mask = mask_q;
  assign busy = (state_q == S_APPLY);
  assign done = (state_q == S_DONE);

`ifdef TT_CHECK_EN
  logic mis_q, mis_d;
  logic accept, enter_done;

  assign accept     = (state_q == S_IDLE) && start;
  assign enter_done = (state_q == S_APPLY) && (state_d == S_DONE);

  // mask_d already holds the final sample on the edge entering DONE.
  always_comb begin
    mis_d = mis_q;
    if (accept) begin
      mis_d = 1'b0;
    end else if (enter_done) begin
      mis_d = (mask_d != EXPECTED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign mismatch = mis_q;
`else
  // EXPECTED only feeds the comparator, which this build leaves out.
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
  assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: random truth tables swept by two sweepers
// (SETTLE=0 and SETTLE=2), checked by a queue scoreboard and monitor.
module tb_truth_table_sweeper;

  localparam int S0 = 0;
  localparam int S1 = 2;
  localparam int P0 = (S0 + 1) * 8;
  localparam int P1 = (S1 + 1) * 8;

  typedef struct {
    logic [7:0] tt;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tt_q;

  logic [2:0] vec0, vec1;
  logic [7:0] mask0, mask1;
  logic       busy0, busy1, done0, done1, mis0, mis1;
  logic       f0, f1;

  assign f0 = tt_q[vec0];
  assign f1 = tt_q[vec1];

  truth_table_sweeper #(
    .N(3), .SETTLE(S0), .EXPECTED(8'h42)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vec(vec0), .f_in(f0), .mask(mask0),
    .busy(busy0), .done(done0), .mismatch(mis0)
  );

  truth_table_sweeper #(
    .N(3), .SETTLE(S1), .EXPECTED(8'h42)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vec(vec1), .f_in(f1), .mask(mask1),
    .busy(busy1), .done(done1), .mismatch(mis1)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  int   nvec  = 0;
  int   nfail = 0;
  int   free0 = 0;
  int   free1 = 0;
  int   bcnt0 = 0;
  int   bcnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // f = x'y'z + xyz' evaluated per minterm.
  function automatic logic [7:0] tt_f();
    logic [7:0] r;
    logic [2:0] v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      r[i] = (~v[2] & ~v[1] & v[0]) | (v[2] & v[1] & ~v[0]);
    end
    return r;
  endfunction

  // A sweep accepted at edge c occupies P APPLY cycles plus one DONE
  // cycle plus one IDLE cycle, so the next start can land at c+P+2.
  always @(posedge clk) begin
    if (rst_n && start) begin
      if (cyc >= free0) begin
        q0.push_back('{tt_q, cyc});
        free0 <= cyc + P0 + 2;
      end
      if (cyc >= free1) begin
        q1.push_back('{tt_q, cyc});
        free1 <= cyc + P1 + 2;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic mon_one(
    input  int         k,
    input  int         s,
    input  logic [2:0] v,
    input  logic [7:0] m,
    input  logic       b,
    input  logic       d,
    input  logic       mi,
    input  bit         have,
    input  exp_t       e,
    inout  int         bcnt,
    output bit         pop
  );
    int p;
    int emis;
    p   = (s + 1) * 8;
    pop = 1'b0;
    if (d) begin
      if (!have) begin
        nvec++;
        nfail++;
        $display("FAIL dut%0d done: got a done pulse, expected none", k);
      end else begin
`ifdef TT_CHECK_EN
        emis = (e.tt != 8'h42) ? 1 : 0;
`else
        emis = 0;
`endif
        chk($sformatf("dut%0d mask", k), int'(m), int'(e.tt));
        chk($sformatf("dut%0d done_cycle", k), cyc, e.c + p + 1);
        chk($sformatf("dut%0d busy_at_done", k), int'(b), 0);
        chk($sformatf("dut%0d busy_len", k), bcnt, p);
        chk($sformatf("dut%0d mismatch", k), int'(mi), emis);
        pop = 1'b1;
      end
      bcnt = 0;
    end else if (b) begin
      bcnt++;
      if (!have) begin
        if (bcnt == 1) begin
          nvec++;
          nfail++;
          $display("FAIL dut%0d busy: got busy=1, expected idle", k);
        end
      end else begin
        chk($sformatf("dut%0d vec", k), int'(v),
            (cyc - 1 - e.c) / (s + 1));
        chk($sformatf("dut%0d mismatch_busy", k), int'(mi), 0);
      end
    end else begin
      chk($sformatf("dut%0d idle_vec", k), int'(v), 0);
    end
  endtask

  always @(negedge clk) begin
    bit   h, pp;
    exp_t e;
    if (rst_n) begin
      h = (q0.size() > 0);
      e = h ? q0[0] : '{8'h00, 0};
      mon_one(0, S0, vec0, mask0, busy0, done0, mis0, h, e, bcnt0, pp);
      if (pp) void'(q0.pop_front());
      h = (q1.size() > 0);
      e = h ? q1[0] : '{8'h00, 0};
      mon_one(1, S1, vec1, mask1, busy1, done1, mis1, h, e, bcnt1, pp);
      if (pp) void'(q1.pop_front());
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 &&
             cyc >= free0 && cyc >= free1)) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        nvec++;
        nfail++;
        $display("FAIL wait_idle: got no completion in %0d cycles", n);
        return;
      end
    end
  endtask

  task automatic sweep(input logic [7:0] tt);
    wait_idle();
    tt_q  = tt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_vec0(input logic [2:0] v);
    int n;
    n = 0;
    while (vec0 != v) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        nvec++;
        nfail++;
        $display("FAIL wait_vec0: got vec=%0d, expected %0d", vec0, v);
        return;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " vec0"}, int'(vec0), 0);
    chk({tag, " mask0"}, int'(mask0), 0);
    chk({tag, " busy0"}, int'(busy0), 0);
    chk({tag, " done0"}, int'(done0), 0);
    chk({tag, " mis0"}, int'(mis0), 0);
    chk({tag, " vec1"}, int'(vec1), 0);
    chk({tag, " mask1"}, int'(mask1), 0);
    chk({tag, " busy1"}, int'(busy1), 0);
    chk({tag, " done1"}, int'(done1), 0);
    chk({tag, " mis1"}, int'(mis1), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    tt_q  = 8'h00;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    sweep(tt_f());

    sweep(tt_f());
    wait_vec0(3'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    sweep(tt_f());
    wait_vec0(3'd5);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    q0.delete();
    q1.delete();
    free0 = 0;
    free1 = 0;
    bcnt0 = 0;
    bcnt1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(tt_f());

    sweep(8'hFF);
    sweep(8'h42);

    wait_idle();
    tt_q  = 8'h00;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sweep(8'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
